servo_pwm_bank: RTL and testbench

Parametrised bank of N_CH servo PWM channels on a fixed frame period. Each channel's pulse width either slews toward a commanded target or sweeps autonomously between MIN_US and MAX_US, one STEP_US per frame. The bank sits between the arm's joint controller, which issues commands over a valid/ready port, and the servo pins. It also exports the live per-channel widths for the seven-segment display logic.

---
 rtl/servo_pwm_bank.sv | 158 +++++++++++++++
 tb/tb_servo_pwm_bank.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/servo_pwm_bank.sv
// Bank of servo PWM channels sharing one frame timer. Each channel slews toward
// a commanded width or sweeps between the limits, stepping once per frame.
module servo_pwm_bank #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int N_CH      = 5,
  parameter int PERIOD_US = 20000,
  parameter int MIN_US    = 1000,
  parameter int MAX_US    = 2000,
  parameter int STEP_US   = 10,
  parameter int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CH_W-1:0]   cmd_ch,
  input  logic              cmd_sweep,
  input  logic [15:0]       cmd_width_us,
  output logic              cmd_err,
  output logic [N_CH-1:0]   pwm_out,
  output logic [16*N_CH-1:0] width_us,
  output logic [N_CH-1:0]   at_target,
  output logic              frame_start
);

  localparam int DIV = CLK_HZ / 1_000_000;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int FW  = (PERIOD_US > 1) ? $clog2(PERIOD_US) : 1;
  localparam int CW  = (FW > 16) ? FW : 16;

  localparam logic [15:0] MIN_W  = 16'(MIN_US);
  localparam logic [15:0] MAX_W  = 16'(MAX_US);
  localparam logic [15:0] STEP_W = 16'(STEP_US);
  localparam logic [15:0] MID_W  = 16'((MIN_US + MAX_US) / 2);

  typedef enum logic {TRACK = 1'b0, SWEEP = 1'b1} mode_t;

  logic [PW-1:0] presc_reg;
  logic [FW-1:0] frame_us_reg;
  logic          frame_start_reg;
  logic          cmd_err_reg;
  logic          us_tick;
  logic          wrap;
  logic          cmd_fire;
  logic          ch_ok;
  logic [15:0]   cmd_target;

  assign us_tick = (presc_reg == PW'(DIV - 1));
  // wrap is the edge on which frame_us returns to 0 and all widths update.
  assign wrap    = us_tick && (frame_us_reg == FW'(PERIOD_US - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_reg       <= '0;
      frame_us_reg    <= '0;
      frame_start_reg <= 1'b0;
    end else begin
      presc_reg       <= us_tick ? '0 : presc_reg + 1'b1;
      if (us_tick)
        frame_us_reg  <= wrap ? '0 : frame_us_reg + 1'b1;
      frame_start_reg <= wrap;
    end
  end

  assign cmd_ready   = !wrap;
  assign cmd_fire    = cmd_valid && !wrap;
  assign ch_ok       = (int'(cmd_ch) < N_CH);
  assign frame_start = frame_start_reg;
  assign cmd_err     = cmd_err_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cmd_err_reg <= 1'b0;
    else        cmd_err_reg <= cmd_fire && !ch_ok;
  end

  always_comb begin
    cmd_target = cmd_width_us;
    if (cmd_width_us < MIN_W)      cmd_target = MIN_W;
    else if (cmd_width_us > MAX_W) cmd_target = MAX_W;
  end

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [15:0] width_reg, width_next;
      logic [15:0] target_reg, target_next;
      mode_t       mode_reg, mode_next;
      logic        down_reg, down_next;
      logic        pwm_reg;
      logic        ch_hit;
      logic [16:0] up_sum;
      logic [15:0] dn_diff;

      assign ch_hit  = cmd_fire && ch_ok && (cmd_ch == CH_W'(gi));
      assign up_sum  = {1'b0, width_reg} + {1'b0, STEP_W};
      // Only used once width is known to exceed the step, so no underflow.
      assign dn_diff = width_reg - STEP_W;

      always_comb begin
        width_next  = width_reg;
        target_next = target_reg;
        mode_next   = mode_reg;
        down_next   = down_reg;
        if (wrap) begin
          if (mode_reg == SWEEP) begin
            if (!down_reg) begin
              if (up_sum >= {1'b0, MAX_W}) begin
                width_next = MAX_W;
                down_next  = 1'b1;
              end else begin
                width_next = up_sum[15:0];
              end
            end else begin
              if ({1'b0, width_reg} <= ({1'b0, MIN_W} + {1'b0, STEP_W})) begin
                width_next = MIN_W;
                down_next  = 1'b0;
              end else begin
                width_next = dn_diff;
              end
            end
          end else if (width_reg < target_reg) begin
            width_next = (up_sum >= {1'b0, target_reg}) ? target_reg : up_sum[15:0];
          end else if (width_reg > target_reg) begin
            width_next = ((width_reg - target_reg) <= STEP_W) ? target_reg : dn_diff;
          end
        end else if (ch_hit) begin
          if (cmd_sweep) begin
            mode_next = SWEEP;
            down_next = (width_reg == MAX_W);
          end else begin
            mode_next   = TRACK;
            target_next = cmd_target;
          end
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          width_reg  <= MID_W;
          target_reg <= MID_W;
          mode_reg   <= TRACK;
          down_reg   <= 1'b0;
          pwm_reg    <= 1'b0;
        end else begin
          width_reg  <= width_next;
          target_reg <= target_next;
          mode_reg   <= mode_next;
          down_reg   <= down_next;
          pwm_reg    <= (CW'(frame_us_reg) < CW'(width_reg));
        end
      end

      assign pwm_out[gi]            = pwm_reg;
      assign width_us[16*gi +: 16]  = width_reg;
      assign at_target[gi]          = (mode_reg == TRACK) && (width_reg == target_reg);
    end
  endgenerate

endmodule

// File: tb/tb_servo_pwm_bank.sv
// Self-checking bench for servo_pwm_bank: per-cycle reference model, a command
// table, hand sequences for boundary collisions/errors/reset, and random traffic.
module tb_servo_pwm_bank;

  localparam int CLK_HZ    = 2_000_000;
  localparam int N_CH      = 5;
  localparam int PERIOD_US = 100;
  localparam int MIN_US    = 20;
  localparam int MAX_US    = 60;
  localparam int STEP_US   = 2;
  localparam int DIV       = CLK_HZ / 1_000_000;
  localparam int FRAME     = PERIOD_US * DIV;
  localparam int MID       = (MIN_US + MAX_US) / 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmd_valid = 1'b0;
  logic cmd_ready;
  logic [2:0] cmd_ch = '0;
  logic cmd_sweep = 1'b0;
  logic [15:0] cmd_width_us = '0;
  logic cmd_err;
  logic [N_CH-1:0] pwm_out;
  logic [16*N_CH-1:0] width_us;
  logic [N_CH-1:0] at_target;
  logic frame_start;

  servo_pwm_bank #(
    .CLK_HZ(CLK_HZ), .N_CH(N_CH), .PERIOD_US(PERIOD_US),
    .MIN_US(MIN_US), .MAX_US(MAX_US), .STEP_US(STEP_US)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ch(cmd_ch), .cmd_sweep(cmd_sweep), .cmd_width_us(cmd_width_us),
    .cmd_err(cmd_err), .pwm_out(pwm_out), .width_us(width_us),
    .at_target(at_target), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model: state indexed by edges since reset release.
  int ne;
  int mw[N_CH];
  int mt[N_CH];
  bit msw[N_CH];
  bit mdn[N_CH];
  logic [N_CH-1:0] exp_pwm;
  bit exp_fs;
  bit exp_err;

  typedef struct {
    int ch;
    bit sweep;
    int width;
    int frames;
    int exp_w;
    bit exp_at;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    ne = 0;
    for (int i = 0; i < N_CH; i++) begin
      mw[i] = MID; mt[i] = MID; msw[i] = 0; mdn[i] = 0;
    end
    exp_pwm = '0; exp_fs = 0; exp_err = 0;
  endtask

  task automatic model_edge();
    int k;
    int fu;
    bit rdy;
    int c;
    k   = ne + 1;
    fu  = (ne / DIV) % PERIOD_US;
    rdy = (k % FRAME) != 0;
    for (int i = 0; i < N_CH; i++) exp_pwm[i] = (fu < mw[i]);
    exp_fs  = !rdy;
    exp_err = 0;
    if (!rdy) begin
      for (int i = 0; i < N_CH; i++) begin
        if (msw[i]) begin
          if (!mdn[i]) begin
            mw[i] = mw[i] + STEP_US;
            if (mw[i] >= MAX_US) begin mw[i] = MAX_US; mdn[i] = 1; end
          end else begin
            mw[i] = mw[i] - STEP_US;
            if (mw[i] <= MIN_US) begin mw[i] = MIN_US; mdn[i] = 0; end
          end
        end else if (mw[i] < mt[i]) begin
          mw[i] = (mw[i] + STEP_US < mt[i]) ? mw[i] + STEP_US : mt[i];
        end else if (mw[i] > mt[i]) begin
          mw[i] = (mw[i] - STEP_US > mt[i]) ? mw[i] - STEP_US : mt[i];
        end
      end
    end else if (cmd_valid) begin
      c = int'(cmd_ch);
      if (c >= N_CH) begin
        exp_err = 1;
      end else if (cmd_sweep) begin
        msw[c] = 1;
        mdn[c] = (mw[c] == MAX_US);
      end else begin
        msw[c] = 0;
        mt[c] = int'(cmd_width_us);
        if (mt[c] < MIN_US) mt[c] = MIN_US;
        if (mt[c] > MAX_US) mt[c] = MAX_US;
      end
    end
    ne = k;
  endtask

  task automatic check_all();
    logic [16*N_CH-1:0] ew;
    logic [N_CH-1:0] ea;
    bit in_range;
    in_range = 1;
    for (int i = 0; i < N_CH; i++) begin
      ew[16*i +: 16] = 16'(mw[i]);
      ea[i] = !msw[i] && (mw[i] == mt[i]);
      if (width_us[16*i +: 16] < 16'(MIN_US) || width_us[16*i +: 16] > 16'(MAX_US)) in_range = 0;
    end
    chk("pwm_out", pwm_out, exp_pwm);
    chk("width_us", width_us, ew);
    chk("at_target", at_target, ea);
    chk("frame_start", frame_start, exp_fs);
    chk("cmd_err", cmd_err, exp_err);
    chk("cmd_ready", cmd_ready, ((ne + 1) % FRAME) != 0);
    chk("width_range", in_range, 1);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic send_cmd(input int ch, input bit sweep, input int w);
    bit acc;
    acc = 0;
    cmd_valid = 1; cmd_ch = 3'(ch); cmd_sweep = sweep; cmd_width_us = 16'(w);
    for (int g = 0; g < 4 && !acc; g++) begin
      acc = cmd_ready;
      step();
    end
    cmd_valid = 0;
    chk("cmd_accept", acc, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hc;
    bit acc;
    logic [16*N_CH-1:0] mid_all;
    for (int i = 0; i < N_CH; i++) mid_all[16*i +: 16] = 16'(MID);

    tbl[0] = '{2, 1'b0, 50,  5,  50, 1'b1};
    tbl[1] = '{0, 1'b0, 100, 10, 60, 1'b1};
    tbl[2] = '{0, 1'b0, 5,   20, 20, 1'b1};
    tbl[3] = '{3, 1'b0, 45,  2,  44, 1'b0};
    tbl[4] = '{3, 1'b0, 45,  1,  45, 1'b1};
    tbl[5] = '{1, 1'b0, 40,  1,  40, 1'b1};

    // Reset values while held in reset.
    #23;
    chk("rst_width", width_us, mid_all);
    chk("rst_pwm", pwm_out, '0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_at_target", at_target, {N_CH{1'b1}});
    chk("rst_frame_start", frame_start, 0);
    chk("rst_cmd_err", cmd_err, 0);
    @(negedge clk);
    rst_n = 1;
    model_reset();

    // First frame: high-phase length and first frame_start.
    hc = 0;
    for (int c = 0; c < FRAME; c++) begin
      step();
      hc += int'(pwm_out[0]);
    end
    chk("pwm_high_cycles", hc, MID * DIV);
    chk("first_frame_start", frame_start, 1);

    // Table of track/clamp commands with settled expectations.
    for (int v = 0; v < 6; v++) begin
      send_cmd(tbl[v].ch, tbl[v].sweep, tbl[v].width);
      run(tbl[v].frames * FRAME);
      chk("tbl_width", width_us[16*tbl[v].ch +: 16], tbl[v].exp_w);
      chk("tbl_at_target", at_target[tbl[v].ch], tbl[v].exp_at);
    end

    // Sweep ch4 from mid: up to MAX, reverse, down to MIN, reverse.
    send_cmd(4, 1'b1, 0);
    run(10 * FRAME);
    chk("sweep_max", width_us[16*4 +: 16], MAX_US);
    chk("sweep_not_at_target", at_target[4], 0);
    run(FRAME);
    chk("sweep_turn_down", width_us[16*4 +: 16], MAX_US - STEP_US);
    run(19 * FRAME);
    chk("sweep_min", width_us[16*4 +: 16], MIN_US);
    run(FRAME);
    chk("sweep_turn_up", width_us[16*4 +: 16], MIN_US + STEP_US);
    send_cmd(4, 1'b0, MID);

    // Command held across a frame boundary.
    for (int g = 0; g < FRAME + 2 && cmd_ready; g++) step();
    chk("ready_low_boundary", cmd_ready, 0);
    cmd_valid = 1; cmd_ch = 3'd1; cmd_sweep = 0; cmd_width_us = 16'(30);
    step();
    chk("ready_after_boundary", cmd_ready, 1);
    step();
    cmd_valid = 0;
    chk("collision_accepted", at_target[1], 0);

    // Out-of-range channel.
    cmd_valid = 1; cmd_ch = 3'd7; cmd_sweep = 0; cmd_width_us = 16'(55);
    step();
    cmd_valid = 0;
    chk("err_pulse", cmd_err, 1);
    step();
    chk("err_clear", cmd_err, 0);

    // Random command traffic.
    for (int c = 0; c < 30 * FRAME; c++) begin
      if (!cmd_valid && $urandom_range(19, 0) == 0) begin
        cmd_valid = 1;
        cmd_ch = 3'($urandom_range(7, 0));
        cmd_sweep = 1'($urandom_range(1, 0));
        cmd_width_us = 16'($urandom_range(100, 0));
      end
      acc = cmd_valid && cmd_ready;
      step();
      if (acc) cmd_valid = 0;
    end
    cmd_valid = 0;

    // Asynchronous reset during a ch1 high phase while sweeping.
    send_cmd(1, 1'b1, 0);
    for (int g = 0; g < 2 * FRAME && !pwm_out[1]; g++) step();
    chk("ch1_high_found", pwm_out[1], 1);
    #2;
    rst_n = 0;
    #1;
    chk("async_pwm_low", pwm_out, '0);
    chk("async_width_mid", width_us, mid_all);
    chk("async_at_target", at_target, {N_CH{1'b1}});
    @(negedge clk);
    rst_n = 1;
    model_reset();
    run(FRAME + 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
